bp_predictor_ctrl: RTL and testbench

Branch-predictor control stage that sits between the fetch/execute pipeline and the two-read/one-write branch-prediction cache.
- Issues fetch-time guesses from cache read port 0.
- At execute-time resolution, reads the entry via port 1, computes the updated saturating counter and drives the cache write port one cycle later.
- Forwards the pending write to both reads.
- Keeps branch and mispredict statistics counters.

---
 rtl/bp_predictor_ctrl.sv | 153 +++++++++++++++
 tb/tb_bp_predictor_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_predictor_ctrl.sv
// ---------------------------------------------------------------------------
// bp_predictor_ctrl
//
// Control stage between the fetch/execute pipeline and a two-read/one-write
// branch-prediction cache of saturating counters.
//   - Read port 0 serves fetch-time guesses.
//   - Read port 1 fetches the counter of a branch being resolved. The updated
//     counter is registered and driven on the write port one cycle later.
//   - The registered (pending) write is forwarded to both read ports, so a
//     same-PC check or guess in the following cycle sees the newest value.
//   - Saturating statistics counters track resolved branches and mispredicts.
//
// Ports
//   i_clk               clock
//   i_reset             asynchronous reset, active low
//   i_guess_pc          fetch PC to predict
//   o_guess_taken       combinational prediction for i_guess_pc
//   i_check_valid       a resolved branch is present this cycle
//   i_check_pc          PC of the resolved branch
//   i_check_taken       actual outcome
//   i_check_pred        prediction originally issued for the branch
//   o_cache_ra0         cache read address 0 (= i_guess_pc)
//   i_cache_dout0       cache port 0 data
//   i_cache_hit0        cache port 0 hit
//   o_cache_ra1         cache read address 1 (= i_check_pc)
//   i_cache_dout1       cache port 1 data
//   i_cache_hit1        cache port 1 hit
//   o_cache_wa          cache write address
//   o_cache_din         cache write data
//   o_cache_we          cache write enable
//   i_stat_clr          synchronous clear of the statistics counters
//   o_stat_branches     resolved branch count (saturating)
//   o_stat_mispredicts  mispredict count (saturating)
// ---------------------------------------------------------------------------
module bp_predictor_ctrl #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned CWIDTH = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [AWIDTH-1:0] i_guess_pc,
    output logic              o_guess_taken,
    input  logic              i_check_valid,
    input  logic [AWIDTH-1:0] i_check_pc,
    input  logic              i_check_taken,
    input  logic              i_check_pred,
    output logic [AWIDTH-1:0] o_cache_ra0,
    input  logic [CWIDTH-1:0] i_cache_dout0,
    input  logic              i_cache_hit0,
    output logic [AWIDTH-1:0] o_cache_ra1,
    input  logic [CWIDTH-1:0] i_cache_dout1,
    input  logic              i_cache_hit1,
    output logic [AWIDTH-1:0] o_cache_wa,
    output logic [CWIDTH-1:0] o_cache_din,
    output logic              o_cache_we,
    input  logic              i_stat_clr,
    output logic [31:0]       o_stat_branches,
    output logic [31:0]       o_stat_mispredicts
);

    localparam logic [CWIDTH-1:0] CntMax    = {CWIDTH{1'b1}};
    localparam logic [CWIDTH-1:0] CntMin    = '0;
    localparam logic [CWIDTH-1:0] CntWeakT  = CWIDTH'(2 ** (CWIDTH - 1));
    localparam logic [CWIDTH-1:0] CntWeakNt = CWIDTH'(2 ** (CWIDTH - 1) - 1);

    // Pending write (also the cache write port)
    logic              r_we;
    logic [AWIDTH-1:0] r_wa;
    logic [CWIDTH-1:0] r_din;

    logic [31:0]       r_branches;
    logic [31:0]       r_mispredicts;

    // Effective read data after forwarding
    logic              w_fwd0;
    logic              w_fwd1;
    logic              w_hit0;
    logic              w_hit1;
    logic [CWIDTH-1:0] w_data0;
    logic [CWIDTH-1:0] w_data1;
    logic [CWIDTH-1:0] w_next;
    logic              w_mispredict;
    logic [31:0]       w_branches_d;
    logic [31:0]       w_mispredicts_d;

    assign o_cache_ra0 = i_guess_pc;
    assign o_cache_ra1 = i_check_pc;

    assign w_fwd0  = r_we && (r_wa == i_guess_pc);
    assign w_fwd1  = r_we && (r_wa == i_check_pc);
    assign w_hit0  = w_fwd0 | i_cache_hit0;
    assign w_hit1  = w_fwd1 | i_cache_hit1;
    assign w_data0 = w_fwd0 ? r_din : i_cache_dout0;
    assign w_data1 = w_fwd1 ? r_din : i_cache_dout1;

    assign o_guess_taken = w_hit0 & w_data0[CWIDTH-1];

    always_comb begin
        w_next = CntWeakNt;
        if (w_hit1) begin
            if (i_check_taken) begin
                w_next = (w_data1 == CntMax) ? w_data1 : w_data1 + 1'b1;
            end else begin
                w_next = (w_data1 == CntMin) ? w_data1 : w_data1 - 1'b1;
            end
        end else begin
            w_next = i_check_taken ? CntWeakT : CntWeakNt;
        end
    end

    assign w_mispredict = i_check_valid && (i_check_pred != i_check_taken);

    always_comb begin
        w_branches_d    = r_branches;
        w_mispredicts_d = r_mispredicts;
        if (i_stat_clr) begin
            w_branches_d    = '0;
            w_mispredicts_d = '0;
        end else begin
            if (i_check_valid && !(&r_branches)) begin
                w_branches_d = r_branches + 32'd1;
            end
            if (w_mispredict && !(&r_mispredicts)) begin
                w_mispredicts_d = r_mispredicts + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_we          <= 1'b0;
            r_wa          <= '0;
            r_din         <= '0;
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else begin
            r_we          <= i_check_valid;
            if (i_check_valid) begin
                r_wa  <= i_check_pc;
                r_din <= w_next;
            end
            r_branches    <= w_branches_d;
            r_mispredicts <= w_mispredicts_d;
        end
    end

    assign o_cache_we         = r_we;
    assign o_cache_wa         = r_wa;
    assign o_cache_din        = r_din;
    assign o_stat_branches    = r_branches;
    assign o_stat_mispredicts = r_mispredicts;

endmodule

// File: tb/tb_bp_predictor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_predictor_ctrl
//
// Randomized bench with an architectural reference model: a table of counters
// per PC that is updated the moment a branch resolves, plus branch/mispredict
// totals. A small behavioural cache driven by the DUT write port supplies read
// data. Expected guesses and per-cycle write/stat values go into queues that a
// negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_bp_predictor_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 2;
    localparam int unsigned NPC = 8;

    logic          i_clk;
    logic          i_reset;
    logic [AW-1:0] i_guess_pc;
    logic          o_guess_taken;
    logic          i_check_valid;
    logic [AW-1:0] i_check_pc;
    logic          i_check_taken;
    logic          i_check_pred;
    logic [AW-1:0] o_cache_ra0;
    logic [CW-1:0] i_cache_dout0;
    logic          i_cache_hit0;
    logic [AW-1:0] o_cache_ra1;
    logic [CW-1:0] i_cache_dout1;
    logic          i_cache_hit1;
    logic [AW-1:0] o_cache_wa;
    logic [CW-1:0] o_cache_din;
    logic          o_cache_we;
    logic          i_stat_clr;
    logic [31:0]   o_stat_branches;
    logic [31:0]   o_stat_mispredicts;

    bp_predictor_ctrl #(.AWIDTH(AW), .CWIDTH(CW)) dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_guess_pc         (i_guess_pc),
        .o_guess_taken      (o_guess_taken),
        .i_check_valid      (i_check_valid),
        .i_check_pc         (i_check_pc),
        .i_check_taken      (i_check_taken),
        .i_check_pred       (i_check_pred),
        .o_cache_ra0        (o_cache_ra0),
        .i_cache_dout0      (i_cache_dout0),
        .i_cache_hit0       (i_cache_hit0),
        .o_cache_ra1        (o_cache_ra1),
        .i_cache_dout1      (i_cache_dout1),
        .i_cache_hit1       (i_cache_hit1),
        .o_cache_wa         (o_cache_wa),
        .o_cache_din        (o_cache_din),
        .o_cache_we         (o_cache_we),
        .i_stat_clr         (i_stat_clr),
        .o_stat_branches    (o_stat_branches),
        .o_stat_mispredicts (o_stat_mispredicts)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [AW-1:0] pc_tab [NPC];
    initial begin
        pc_tab[0] = 32'h0000_0100;
        pc_tab[1] = 32'h0000_0200;
        pc_tab[2] = 32'h0000_0104;
        pc_tab[3] = 32'h0000_0300;
        pc_tab[4] = 32'h0000_1100;
        pc_tab[5] = 32'h0000_0204;
        pc_tab[6] = 32'hFFFF_FF00;
        pc_tab[7] = 32'h0000_0000;
    end

    // Behavioural cache (state owned by the "parent")
    int c_cnt [NPC];
    bit c_vld [NPC];

    // Architectural reference model
    int          m_cnt [NPC];
    bit          m_vld [NPC];
    longint      m_br;
    longint      m_mp;

    typedef struct {
        int   cyc;
        logic g;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic        chk_wa;
        logic [31:0] wa;
        logic [1:0]  din;
        logic [31:0] br;
        logic [31:0] mp;
    } sexp_t;

    gexp_t gq[$];
    sexp_t sq[$];
    bit    sb_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        for (int i = 0; i < NPC; i++) if (pc_tab[i] == a) return i;
        return -1;
    endfunction

    // Cache array updated by the DUT write port at the clock edge
    always @(posedge i_clk) begin
        if (i_reset && o_cache_we) begin
            int k;
            k = idx_of(o_cache_wa);
            if (k < 0) begin
                n_fail++;
                $display("FAIL cache_wa_unknown: got %h", o_cache_wa);
            end else begin
                c_cnt[k] <= int'(o_cache_din);
                c_vld[k] <= 1'b1;
            end
        end
    end

    // Monitor
    always @(negedge i_clk) begin
        if (sb_en) begin
            gexp_t g;
            sexp_t s;
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                g = gq.pop_front();
                chk("guess_taken", {31'd0, o_guess_taken}, {31'd0, g.g});
                chk("ra0", o_cache_ra0, i_guess_pc);
            end
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk("cache_we", {31'd0, o_cache_we}, {31'd0, s.we});
                if (s.chk_wa) begin
                    chk("cache_wa", o_cache_wa, s.wa);
                    chk("cache_din", {30'd0, o_cache_din}, {30'd0, s.din});
                end
                chk("stat_branches", o_stat_branches, s.br);
                chk("stat_mispredicts", o_stat_mispredicts, s.mp);
            end
        end
    end

    function automatic int next_cnt(input bit vld, input int cur, input bit tk);
        int cmax;
        cmax = (1 << CW) - 1;
        if (!vld) return tk ? (1 << (CW - 1)) : (1 << (CW - 1)) - 1;
        if (tk) return (cur == cmax) ? cur : cur + 1;
        return (cur == 0) ? 0 : cur - 1;
    endfunction

    // Drive one cycle of stimulus (called #1 after a posedge) and record the
    // expected guess for this cycle and the expected write/stats for the next.
    task automatic do_cycle(input int gi, input bit cv, input int ci, input bit tk,
                            input bit pr, input bit clr);
        int    nxt;
        sexp_t s;
        i_guess_pc    = pc_tab[gi];
        i_cache_hit0  = c_vld[gi];
        i_cache_dout0 = c_vld[gi] ? CW'(c_cnt[gi]) : CW'($urandom_range(0, 3));
        i_check_valid = cv;
        i_check_pc    = pc_tab[ci];
        i_check_taken = tk;
        i_check_pred  = pr;
        i_cache_hit1  = c_vld[ci];
        i_cache_dout1 = c_vld[ci] ? CW'(c_cnt[ci]) : CW'($urandom_range(0, 3));
        i_stat_clr    = clr;

        gq.push_back('{cyc: cyc, g: m_vld[gi] && (m_cnt[gi] >= (1 << (CW - 1)))});

        nxt = next_cnt(m_vld[ci], m_cnt[ci], tk);
        if (clr) begin
            m_br = 0;
            m_mp = 0;
        end else if (cv) begin
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (pr != tk && m_mp < 64'hFFFF_FFFF) m_mp++;
        end
        s.cyc    = cyc + 1;
        s.we     = cv;
        s.chk_wa = cv;
        s.wa     = pc_tab[ci];
        s.din    = 2'(nxt);
        s.br     = 32'(m_br);
        s.mp     = 32'(m_mp);
        sq.push_back(s);
        if (cv) begin
            m_cnt[ci] = nxt;
            m_vld[ci] = 1'b1;
        end

        @(posedge i_clk);
        #1;
    endtask

    // After reset the architecture is whatever the cache holds.
    task automatic after_reset_release();
        for (int i = 0; i < NPC; i++) begin
            m_cnt[i] = c_cnt[i];
            m_vld[i] = c_vld[i];
        end
        m_br = 0;
        m_mp = 0;
        sq.push_back('{cyc: cyc, we: 1'b0, chk_wa: 1'b1, wa: 32'd0, din: 2'd0,
                       br: 32'd0, mp: 32'd0});
        sb_en = 1'b1;
    endtask

    initial begin
        i_reset       = 1'b0;
        i_guess_pc    = '0;
        i_check_valid = 1'b0;
        i_check_pc    = '0;
        i_check_taken = 1'b0;
        i_check_pred  = 1'b0;
        i_cache_dout0 = '0;
        i_cache_hit0  = 1'b0;
        i_cache_dout1 = '0;
        i_cache_hit1  = 1'b0;
        i_stat_clr    = 1'b0;
        for (int i = 0; i < NPC; i++) begin
            c_cnt[i] = int'($urandom_range(0, 3));
            c_vld[i] = (i >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        c_cnt[2] = 3;
        c_vld[2] = 1'b1;
        c_cnt[3] = 0;
        c_vld[3] = 1'b1;

        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        after_reset_release();

        // Miss on 0x100, taken -> weakly taken write
        do_cycle(0, 1, 0, 1, 1, 0);
        // Saturation at 3 (taken) and at 0 (not taken)
        do_cycle(2, 1, 2, 1, 1, 0);
        do_cycle(3, 1, 3, 0, 0, 0);
        // Back-to-back on 0x200 (miss), guess 0x200 sees forwarded value
        do_cycle(1, 1, 1, 1, 1, 0);
        do_cycle(1, 1, 1, 1, 1, 0);
        do_cycle(1, 0, 0, 0, 0, 0);
        // Three mispredicts, then clear with a concurrent check
        do_cycle(4, 1, 4, 1, 0, 0);
        do_cycle(4, 1, 4, 1, 0, 0);
        do_cycle(4, 1, 4, 1, 0, 0);
        do_cycle(4, 1, 4, 1, 0, 1);
        do_cycle(4, 0, 4, 0, 0, 0);

        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                // Reset while a write is pending
                do_cycle(5, 1, 5, 1, 0, 0);
                sb_en = 1'b0;
                #1;
                i_reset = 1'b0;
                #1;
                chk("rst_cache_we", {31'd0, o_cache_we}, 32'd0);
                chk("rst_cache_wa", o_cache_wa, 32'd0);
                chk("rst_branches", o_stat_branches, 32'd0);
                chk("rst_mispredicts", o_stat_mispredicts, 32'd0);
                gq.delete();
                sq.delete();
                i_check_valid = 1'b0;
                @(posedge i_clk);
                #1;
                i_reset = 1'b1;
                after_reset_release();
            end
            do_cycle(int'($urandom_range(0, NPC - 1)),
                     ($urandom_range(0, 9) < 7),
                     int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 39) == 0));
        end

        @(negedge i_clk);
        #1;
        chk("drain_guess_q", gq.size(), 32'd0);
        chk("drain_state_q", sq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
